// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared definitions for the pc_sequencer slice.
//   - seq_state_t : sequencer states (RUN, HOLD, HOLD_REDIR)
//   - RESET_PC_DEFAULT / EXC_VECTOR_DEFAULT : default parameter values
//   - PC_INC : sequential fetch increment
package pc_seq_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    HOLD       = 2'd1,
    HOLD_REDIR = 2'd2
  } seq_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h8000_0180;
  localparam logic [31:0] PC_INC             = 32'd4;

endpackage

// File: rtl/pc_sequencer_shl2.sv
// pc_sequencer_shl2: 32-bit logical shift left by two (word offset to byte offset).
// Ports:
//   din  - 32-bit input value
//   dout - din << 2, upper two bits discarded
module pc_sequencer_shl2 (
  input  logic [31:0] din,
  output logic [31:0] dout
);

  assign dout = {din[29:0], 2'b00};

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter controller for the 32-bit MIPS fetch stage.
// Selects PC+4, branch, jump or register-jump target; holds under stall and
// buffers the first redirect seen while stalled.
// Optional feature macro: PC_SEQ_EXC_VECTOR_EN (adds exc input / epc output).
// Ports:
//   clk, rst         - clock (rising edge), asynchronous active-high reset
//   stall            - fetch stage not accepting; hold pc
//   branch_taken     - taken conditional branch, offset branch_imm (words, signed)
//   jump/jump_target - J/JAL with 26-bit instr_index
//   jr/jr_addr       - JR/JALR with 32-bit register address
//   pc, pc_plus4     - current fetch address and its sequential successor
//   redirect         - registered pulse: pc loaded with non-sequential target
//   misalign         - registered pulse: accepted jr_addr had low bits set
//   pending          - redirect captured, waiting for stall release
//   exc, epc         - (feature only) exception request and saved pc
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
`ifdef PC_SEQ_EXC_VECTOR_EN
  , parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_imm,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        jr,
  input  logic [31:0] jr_addr,
`ifdef PC_SEQ_EXC_VECTOR_EN
  input  logic        exc,
  output logic [31:0] epc,
`endif
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        redirect,
  output logic        misalign,
  output logic        pending
);

  seq_state_t  state;
  logic [31:0] pend_reg;
  logic [31:0] br_off;
  logic [31:0] branch_tgt;
  logic [31:0] jump_tgt;
  logic [31:0] jr_tgt;
  logic        req_any;
  logic        req_mis;
  logic [31:0] req_tgt;

  assign pc_plus4 = pc + PC_INC;

  pc_sequencer_shl2 u_shl2 (
    .din  ({{16{branch_imm[15]}}, branch_imm}),
    .dout (br_off)
  );

  assign branch_tgt = pc_plus4 + br_off;
  assign jump_tgt   = {pc_plus4[31:28], jump_target, 2'b00};
  assign jr_tgt     = {jr_addr[31:2], 2'b00};

  // Request arbitration: jr over jump over branch; lower requests are dropped.
  always_comb begin
    req_any = 1'b0;
    req_mis = 1'b0;
    req_tgt = 32'h0000_0000;
    if (jr) begin
      req_any = 1'b1;
      req_mis = (jr_addr[1:0] != 2'b00);
      req_tgt = jr_tgt;
    end else if (jump) begin
      req_any = 1'b1;
      req_tgt = jump_tgt;
    end else if (branch_taken) begin
      req_any = 1'b1;
      req_tgt = branch_tgt;
    end else begin
      req_any = 1'b0;
    end
  end

  // Sequencer FSM with registered pc, pulses and pending flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      pc       <= RESET_PC;
      pend_reg <= 32'h0000_0000;
      redirect <= 1'b0;
      misalign <= 1'b0;
      pending  <= 1'b0;
`ifdef PC_SEQ_EXC_VECTOR_EN
      epc      <= 32'h0000_0000;
`endif
    end else begin
      redirect <= 1'b0;
      misalign <= 1'b0;
`ifdef PC_SEQ_EXC_VECTOR_EN
      if (exc) begin
        // Exception beats stall and discards any buffered redirect.
        pc       <= EXC_VECTOR;
        epc      <= pc;
        redirect <= 1'b1;
        pending  <= 1'b0;
        state    <= RUN;
      end else
`endif
      begin
        case (state)
          // HOLD releases on the same edge stall drops, exactly like RUN.
          RUN, HOLD: begin
            if (!stall) begin
              state <= RUN;
              if (req_any) begin
                pc       <= req_tgt;
                redirect <= 1'b1;
                misalign <= req_mis;
              end else begin
                pc <= pc_plus4;
              end
            end else if (req_any) begin
              pend_reg <= req_tgt;
              misalign <= req_mis;
              pending  <= 1'b1;
              state    <= HOLD_REDIR;
            end else begin
              state <= HOLD;
            end
          end
          // First captured target wins; later requests are ignored here.
          HOLD_REDIR: begin
            if (!stall) begin
              pc       <= pend_reg;
              redirect <= 1'b1;
              pending  <= 1'b0;
              state    <= RUN;
            end else begin
              state <= HOLD_REDIR;
            end
          end
          default: begin
            state   <= RUN;
            pending <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: table-driven self-checking bench for pc_sequencer, plus
// hand-written sequences for asynchronous reset in HOLD_REDIR and (when
// PC_SEQ_EXC_VECTOR_EN is defined) the exception path.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_imm;
  logic        jump;
  logic [25:0] jump_target;
  logic        jr;
  logic [31:0] jr_addr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        redirect;
  logic        misalign;
  logic        pending;
`ifdef PC_SEQ_EXC_VECTOR_EN
  logic        exc;
  logic [31:0] epc;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_imm   (branch_imm),
    .jump         (jump),
    .jump_target  (jump_target),
    .jr           (jr),
    .jr_addr      (jr_addr),
`ifdef PC_SEQ_EXC_VECTOR_EN
    .exc          (exc),
    .epc          (epc),
`endif
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .redirect     (redirect),
    .misalign     (misalign),
    .pending      (pending)
  );

  typedef struct {
    logic        stall;
    logic        bt;
    logic [15:0] imm;
    logic        jmp;
    logic [25:0] jt;
    logic        jr;
    logic [31:0] ja;
    logic [31:0] e_pc;
    logic        e_red;
    logic        e_mis;
    logic        e_pend;
  } vec_t;

  localparam int NV = 23;
  vec_t tbl [NV];

  function automatic vec_t mk(logic s, logic b, logic [15:0] im, logic j, logic [25:0] t,
                              logic r, logic [31:0] a, logic [31:0] ep,
                              logic er, logic em, logic epd);
    vec_t v;
    v.stall = s; v.bt = b; v.imm = im; v.jmp = j; v.jt = t; v.jr = r; v.ja = a;
    v.e_pc = ep; v.e_red = er; v.e_mis = em; v.e_pend = epd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    stall = 1'b0; branch_taken = 1'b0; branch_imm = 16'h0000; jump = 1'b0;
    jump_target = 26'h0; jr = 1'b0; jr_addr = 32'h0;
`ifdef PC_SEQ_EXC_VECTOR_EN
    exc = 1'b0;
`endif
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_outs(input string tag, input logic [31:0] e_pc, input logic e_red,
                          input logic e_mis, input logic e_pend);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".pc_plus4"}, pc_plus4, e_pc + 32'd4);
    chk({tag, ".redirect"}, {31'd0, redirect}, {31'd0, e_red});
    chk({tag, ".misalign"}, {31'd0, misalign}, {31'd0, e_mis});
    chk({tag, ".pending"}, {31'd0, pending}, {31'd0, e_pend});
  endtask

  initial begin
    //            stall bt imm       jmp jt          jr  jr_addr         exp pc          red mis pend
    tbl[0]  = mk(1'b0,1'b0,16'h0000,1'b0,26'h0,     1'b0,32'h0,          32'h0000_0004,1'b0,1'b0,1'b0);
    tbl[1]  = mk(1'b0,1'b0,16'h0000,1'b0,26'h0,     1'b0,32'h0,          32'h0000_0008,1'b0,1'b0,1'b0);
    tbl[2]  = mk(1'b0,1'b0,16'h0000,1'b0,26'h0,     1'b0,32'h0,          32'h0000_000C,1'b0,1'b0,1'b0);
    tbl[3]  = mk(1'b0,1'b0,16'h0000,1'b0,26'h0,     1'b1,32'h0000_0100,  32'h0000_0100,1'b1,1'b0,1'b0);
    tbl[4]  = mk(1'b0,1'b1,16'hFFFC,1'b0,26'h0,     1'b0,32'h0,          32'h0000_00F4,1'b1,1'b0,1'b0);
    tbl[5]  = mk(1'b0,1'b0,16'h0000,1'b0,26'h0,     1'b1,32'h0000_0100,  32'h0000_0100,1'b1,1'b0,1'b0);
    tbl[6]  = mk(1'b0,1'b1,16'h0003,1'b0,26'h0,     1'b0,32'h0,          32'h0000_0110,1'b1,1'b0,1'b0);
    tbl[7]  = mk(1'b0,1'b0,16'h0000,1'b0,26'h0,     1'b0,32'h0,          32'h0000_0114,1'b0,1'b0,1'b0);
    // jr beats simultaneous jump and branch
    tbl[8]  = mk(1'b0,1'b1,16'h0003,1'b1,26'h5,     1'b1,32'h1000_0040,  32'h1000_0040,1'b1,1'b0,1'b0);
    // jump beats branch
    tbl[9]  = mk(1'b0,1'b1,16'h0003,1'b1,26'h10,    1'b0,32'h0,          32'h1000_0040,1'b1,1'b0,1'b0);
    tbl[10] = mk(1'b0,1'b0,16'h0000,1'b0,26'h0,     1'b0,32'h0,          32'h1000_0044,1'b0,1'b0,1'b0);
    // four stalled cycles: jr (misaligned) in 2nd, jump in 3rd is ignored
    tbl[11] = mk(1'b1,1'b0,16'h0000,1'b0,26'h0,     1'b0,32'h0,          32'h1000_0044,1'b0,1'b0,1'b0);
    tbl[12] = mk(1'b1,1'b0,16'h0000,1'b0,26'h0,     1'b1,32'h0000_2002,  32'h1000_0044,1'b0,1'b1,1'b1);
    tbl[13] = mk(1'b1,1'b0,16'h0000,1'b1,26'h3,     1'b0,32'h0,          32'h1000_0044,1'b0,1'b0,1'b1);
    tbl[14] = mk(1'b1,1'b0,16'h0000,1'b0,26'h0,     1'b0,32'h0,          32'h1000_0044,1'b0,1'b0,1'b1);
    tbl[15] = mk(1'b0,1'b0,16'h0000,1'b0,26'h0,     1'b0,32'h0,          32'h0000_2000,1'b1,1'b0,1'b0);
    tbl[16] = mk(1'b0,1'b0,16'h0000,1'b0,26'h0,     1'b0,32'h0,          32'h0000_2004,1'b0,1'b0,1'b0);
    // HOLD then release without request, then release with a branch
    tbl[17] = mk(1'b1,1'b0,16'h0000,1'b0,26'h0,     1'b0,32'h0,          32'h0000_2004,1'b0,1'b0,1'b0);
    tbl[18] = mk(1'b0,1'b0,16'h0000,1'b0,26'h0,     1'b0,32'h0,          32'h0000_2008,1'b0,1'b0,1'b0);
    tbl[19] = mk(1'b1,1'b0,16'h0000,1'b0,26'h0,     1'b0,32'h0,          32'h0000_2008,1'b0,1'b0,1'b0);
    tbl[20] = mk(1'b0,1'b1,16'hFFFF,1'b0,26'h0,     1'b0,32'h0,          32'h0000_2008,1'b1,1'b0,1'b0);
    // misaligned jr to top of memory, then sequential wrap to zero
    tbl[21] = mk(1'b0,1'b0,16'h0000,1'b0,26'h0,     1'b1,32'hFFFF_FFFF,  32'hFFFF_FFFC,1'b1,1'b1,1'b0);
    tbl[22] = mk(1'b0,1'b0,16'h0000,1'b0,26'h0,     1'b0,32'h0,          32'h0000_0000,1'b0,1'b0,1'b0);

    idle_inputs();
    rst = 1'b1;
    #1;
    chk_outs("reset", 32'h0000_0000, 1'b0, 1'b0, 1'b0);
`ifdef PC_SEQ_EXC_VECTOR_EN
    chk("reset.epc", epc, 32'h0000_0000);
`endif
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      stall = tbl[i].stall; branch_taken = tbl[i].bt; branch_imm = tbl[i].imm;
      jump = tbl[i].jmp; jump_target = tbl[i].jt; jr = tbl[i].jr; jr_addr = tbl[i].ja;
      step();
      chk_outs($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_red, tbl[i].e_mis, tbl[i].e_pend);
    end

    // Asynchronous reset while a redirect is buffered.
    idle_inputs();
    step();
    chk_outs("arst.pre", 32'h0000_0004, 1'b0, 1'b0, 1'b0);
    stall = 1'b1; jump = 1'b1; jump_target = 26'h40;
    step();
    chk_outs("arst.hold", 32'h0000_0004, 1'b0, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk_outs("arst.now", 32'h0000_0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    step();
    chk_outs("arst.run1", 32'h0000_0004, 1'b0, 1'b0, 1'b0);
    step();
    chk_outs("arst.run2", 32'h0000_0008, 1'b0, 1'b0, 1'b0);

`ifdef PC_SEQ_EXC_VECTOR_EN
    // Exception overrides stall and a buffered redirect.
    jr = 1'b1; jr_addr = 32'h0000_0400;
    step();
    chk_outs("exc.setup", 32'h0000_0400, 1'b1, 1'b0, 1'b0);
    idle_inputs();
    stall = 1'b1; jump = 1'b1; jump_target = 26'h80;
    step();
    chk_outs("exc.pend", 32'h0000_0400, 1'b0, 1'b0, 1'b1);
    jump = 1'b0; exc = 1'b1;
    step();
    chk_outs("exc.take", 32'h8000_0180, 1'b1, 1'b0, 1'b0);
    chk("exc.epc", epc, 32'h0000_0400);
    idle_inputs();
    step();
    chk_outs("exc.after", 32'h8000_0184, 1'b0, 1'b0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter controller for the 32-bit MIPS core; selects and sequences the next fetch address.
- Chooses between PC+4, branch target (PC+4 + sign-extended immediate shifted left 2), jump target and register-jump address.
- Holds the PC under stall and buffers a redirect that arrives while stalled.
- Sits between decode/branch-resolution logic and the instruction memory address port.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
EXC_VECTOR, 32'h8000_0180, exception handler address (used only with EXC_VECTOR_EN)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
stall  input  1  hold PC; fetch stage not accepting
branch_taken  input  1  resolved conditional branch, taken
branch_imm  input  16  branch offset, instruction words, signed
jump  input  1  J/JAL request
jump_target  input  26  instr_index field
jr  input  1  JR/JALR request
jr_addr  input  32  register jump address
pc  output  32  current fetch address
pc_plus4  output  32  pc + 4, combinational from pc
redirect  output  1  one-cycle pulse: pc was loaded with a non-sequential target this cycle
misalign  output  1  one-cycle pulse: accepted jr_addr had [1:0] != 0
pending  output  1  redirect captured and awaiting stall release

Behaviour:
- Reset (async, rst=1): pc=RESET_PC, redirect=0, misalign=0, pending=0, state=RUN, pending target cleared.
- Request priority: jr > jump > branch_taken; lower requests in the same cycle are dropped.
- Targets (32-bit, wrap mod 2^32, no overflow flag):
  - branch: pc_plus4 + (sext32(branch_imm) << 2)
  - jump: {pc_plus4[31:28], jump_target, 2'b00}
  - jr: {jr_addr[31:2], 2'b00}; misalign pulses when jr is accepted with jr_addr[1:0] != 0.
- States:
  - RUN, stall=0:
    - request present: pc <= target next edge, redirect=1 that cycle.
    - no request: pc <= pc_plus4.
  - RUN, stall=1:
    - request present: latch target into pend_reg, go to HOLD_REDIR, pending=1.
    - no request: go to HOLD.
    - pc unchanged in both cases.
  - HOLD: pc held.
    - stall=0: behave as RUN this cycle, same edge.
    - stall=1 and request: latch target, go to HOLD_REDIR.
  - HOLD_REDIR: pc held.
    - New requests are ignored; the first captured target wins.
    - stall=0: pc <= pend_reg, redirect=1, pending=0, go to RUN.
- Latency:
  - Request to pc update is one edge when not stalled.
  - A stalled redirect is applied on the first edge with stall=0.
- Reset mid-HOLD_REDIR discards the pending target.
- redirect and misalign are registered pulses, high exactly one cycle after the updating edge.
- pc_plus4 is never registered separately.

Optional Feature:
- Macro: PC_SEQ_EXC_VECTOR_EN.
- When defined:
  - Adds input exc (1) and output epc (32).
  - exc has highest priority, above jr, and overrides stall and any pending target.
  - Next edge: pc <= EXC_VECTOR, epc <= pc, pending cleared, state=RUN, redirect=1.
  - epc resets to 0.
- When undefined: ports absent; behaviour as above.

Decomposition:
- Shared package pc_seq_pkg: state enum (RUN, HOLD, HOLD_REDIR), RESET_PC/EXC_VECTOR defaults, PC_INC=32'd4.
- One sub-module: the existing 32-bit shift-left-by-2 block, instantiated for the branch offset (sext32(branch_imm) into it).
- Jump concatenation stays inline.

Test Plan:
- Reset then 3 free-running cycles, no requests -> pc = 0x0, 0x4, 0x8, 0xC; redirect=0.
- pc=0x100, branch_taken with imm=16'hFFFC -> next pc=0xF4, redirect pulse; imm=16'h0003 -> 0x110.
- pc=0x1000_0040, jump and branch_taken same cycle, jump_target=26'h0000010 -> pc=0x1000_0040 (jump wins; branch dropped).
- stall=1 for 4 cycles, jr with jr_addr=0x0000_2002 in cycle 2, jump in cycle 3:
  - pending=1 and pc held while stalled.
  - misalign pulse at acceptance.
  - After stall drops: pc=0x2000, redirect pulse, pending=0; the cycle-3 jump is ignored.
- rst asserted asynchronously mid-clock while in HOLD_REDIR -> pc=RESET_PC immediately, pending=0; after release pc increments from RESET_PC.
- (PC_SEQ_EXC_VECTOR_EN) pc=0x400, stall=1, pending redirect, exc=1 -> next pc=0x8000_0180, epc=0x400, pending=0.
